dct_stream_driver: RTL and testbench
====================================

Name: dct_stream_driver

Overview:
- Parametrised frame streamer and capture unit for the DCT pipeline.
- Reads an image from a synchronous pixel ROM and drives dct_main-style inputs with LANES pixels per beat.
- Supports stall and multi-frame runs, and counts the beats dct_main emits on its sync strobe.
- Used both as the on-chip test source and as the hardware front end in the DCT pipeline, replacing the old fixed 2-pixel stimulus logic.

Parameters:
- DATA_WIDTH, 8, pixel bit depth.
- OUT_WIDTH, 16, width of each DCT output lane (run-length stage width).
- LANES, 2, pixels per beat. Must be ≥1 and must divide NUM_PIXELS.
- NUM_PIXELS, 65536, pixels per frame.
- ADDR_WIDTH, 16, ROM word address width. Must satisfy 2^ADDR_WIDTH ≥ NUM_PIXELS/LANES.

Ports:
- i_clk  in  1  clock.
- i_resetn  in  1  asynchronous, active-low reset.
- i_start  in  1  one-cycle pulse that starts a run. Ignored while o_busy.
- i_num_frames  in  8  number of frames per run. Sampled on i_start. Value 0 is treated as 1.
- i_stall  in  1  when high, no new ROM address is issued.
- o_mem_addr  out  ADDR_WIDTH  ROM word address; one word holds LANES pixels.
- i_mem_rdata  in  LANES*DATA_WIDTH  ROM data, valid one cycle after address. Lane 0 is in the LSBs.
- o_wdata  out  LANES*DATA_WIDTH  pixel beat to the DCT.
- o_wen  out  1  beat valid.
- i_rdata  in  LANES*OUT_WIDTH  DCT output beat.
- i_rsync  in  1  DCT output beat valid.
- o_busy  out  1  run in progress.
- o_done  out  1  one-cycle pulse at end of run.
- o_frame_idx  out  8  index of the current frame, starting at 0.
- o_out_count  out  32  rsync beats counted in the current run.
- o_checksum  out  32  see Optional Feature.

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs are 0, including o_mem_addr, o_wdata, the counters and o_checksum.
- FSM states: IDLE, STREAM, DRAIN, DONE.
- IDLE → STREAM on i_start. On that edge:
  - latch the frame count (max(i_num_frames,1));
  - clear o_frame_idx, o_out_count and o_checksum;
  - set o_busy=1.
- STREAM:
  - Each cycle with i_stall=0, issue o_mem_addr = current word index, then increment the index.
  - Word indices run 0..NUM_PIXELS/LANES-1.
  - When i_stall=1, o_mem_addr holds and nothing is issued.
  - After the last word is issued, go to DRAIN.
- Write path:
  - Every issued address produces exactly one o_wen=1 beat, exactly 2 cycles after issue (ROM latency plus output register). o_wdata carries that word.
  - Order is preserved. Stall never cancels beats already in flight.
  - o_wen=0 in all other cycles. o_wdata holds its last value when o_wen=0.
- Capture:
  - While o_busy, each cycle with i_rsync=1 increments o_out_count and a per-frame beat counter.
  - i_rsync is ignored in IDLE and DONE.
- DRAIN:
  - Waits until the per-frame beat counter reaches NUM_PIXELS/LANES.
  - If further frames remain: increment o_frame_idx, clear the word index and frame counter, return to STREAM.
  - Otherwise go to DONE.
- DONE: o_done=1 and o_busy=0 for one cycle, then IDLE. o_out_count and o_checksum hold until the next i_start.
- rsync beats that arrive while still in STREAM count toward the current frame.
- A beat count above NUM_PIXELS/LANES is not checked; the counter saturates at that value for the transition.
- Address wrap: the word index never exceeds NUM_PIXELS/LANES-1; it resets per frame.
- i_start asserted while o_busy or in DONE: ignored.
- Simultaneous i_stall and last issue: the stall wins; the last address is issued on the first unstalled cycle.
- Reset asserted mid-run: immediate return to IDLE. In-flight beats are dropped and o_wen falls with the reset.

Optional Feature:
- Macro DCT_STREAM_CHECKSUM_EN.
- Defined: on each counted rsync beat, o_checksum += sum over lanes of each OUT_WIDTH lane, zero-extended, modulo 2^32. Cleared on i_start.
- Undefined: o_checksum is constant 0 and no adder logic is built.

Test Plan:
All scenarios use NUM_PIXELS=16, LANES=2, and a ROM whose word k holds pixels {2k+1, 2k}.
- Single frame, no stall: i_start, i_num_frames=1.
  - Required: o_mem_addr issues 0..7 on consecutive cycles.
  - Required: o_wen is high for 8 cycles starting 2 cycles after first issue; the first o_wdata is 0x0100.
  - Loopback i_rsync=o_wen delayed 10 cycles → o_out_count=8, then one o_done pulse.
- Stall: i_stall high for 3 cycles after address 3 is issued → o_wen gap of exactly 3 cycles. Beats remain 0..7 in order with no duplicates.
- Multi-frame: i_num_frames=3 → o_frame_idx steps 0→1→2. Final o_out_count=24. o_done pulses once.
- Zero frames and start-while-busy: i_num_frames=0 behaves as 1 frame. A second i_start mid-run leaves the run unchanged (o_out_count=8).
- Reset mid-run: assert i_resetn=0 at beat 4 → o_wen, o_busy and the counters are 0 on the same cycle. A new i_start restarts from address 0.
- Checksum (macro defined): with loopback i_rdata={o_wdata zero-extended per lane} → o_checksum=120 (the sum of 0..15). With the macro undefined, o_checksum stays 0.

Source files
------------

// File: rtl/dct_stream_driver.sv
// dct_stream_driver: frame streamer and capture unit for the DCT pipeline.
// Fetches LANES-pixel words from a synchronous ROM, drives them to dct_main
// two cycles after each address is issued, and counts returned sync beats.
// Optional build macro: DCT_STREAM_CHECKSUM_EN adds a running sum of the
// returned lanes on o_checksum; without it o_checksum is tied to zero.
module dct_stream_driver #(
    parameter int DATA_WIDTH = 8,
    parameter int OUT_WIDTH  = 16,
    parameter int LANES      = 2,
    parameter int NUM_PIXELS = 65536,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                        i_clk,
    input  logic                        i_resetn,
    input  logic                        i_start,
    input  logic [7:0]                  i_num_frames,
    input  logic                        i_stall,
    output logic [ADDR_WIDTH-1:0]       o_mem_addr,
    input  logic [LANES*DATA_WIDTH-1:0] i_mem_rdata,
    output logic [LANES*DATA_WIDTH-1:0] o_wdata,
    output logic                        o_wen,
    input  logic [LANES*OUT_WIDTH-1:0]  i_rdata,
    input  logic                        i_rsync,
    output logic                        o_busy,
    output logic                        o_done,
    output logic [7:0]                  o_frame_idx,
    output logic [31:0]                 o_out_count,
    output logic [31:0]                 o_checksum
);

    localparam int NUM_WORDS = NUM_PIXELS / LANES;
    localparam int CNT_W     = $clog2(NUM_WORDS + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_WORD   = ADDR_WIDTH'(NUM_WORDS - 1);
    localparam logic [CNT_W-1:0]      FRAME_BEATS = CNT_W'(NUM_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;

    state_t                      state_q;
    logic [ADDR_WIDTH-1:0]       word_idx_q;
    logic [ADDR_WIDTH-1:0]       mem_addr_q;
    logic                        issue_q;
    logic                        fetch_q;
    logic                        wen_q;
    logic [LANES*DATA_WIDTH-1:0] wdata_q;
    logic                        busy_q;
    logic                        done_q;
    logic [7:0]                  frame_idx_q;
    logic [7:0]                  num_frames_q;
    logic [CNT_W-1:0]            frame_cnt_q;
    logic [31:0]                 out_count_q;

    logic start_accept;
    logic capture;

    // A start is only honoured from IDLE; sync beats only count during a run.
    assign start_accept = (state_q == S_IDLE) && i_start;
    assign capture      = i_rsync && ((state_q == S_STREAM) || (state_q == S_DRAIN));

    // Run control FSM: address issue, frame sequencing and beat counting.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state_q      <= S_IDLE;
            word_idx_q   <= '0;
            mem_addr_q   <= '0;
            issue_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            frame_idx_q  <= '0;
            num_frames_q <= '0;
            frame_cnt_q  <= '0;
            out_count_q  <= '0;
        end else begin
            issue_q <= 1'b0;
            // Per-frame counter saturates so excess beats cannot wrap it.
            if (capture) begin
                out_count_q <= out_count_q + 32'd1;
                if (frame_cnt_q != FRAME_BEATS) begin
                    frame_cnt_q <= frame_cnt_q + CNT_W'(1);
                end
            end
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (i_start) begin
                        num_frames_q <= (i_num_frames == 8'd0) ? 8'd1 : i_num_frames;
                        frame_idx_q  <= '0;
                        out_count_q  <= '0;
                        frame_cnt_q  <= '0;
                        word_idx_q   <= '0;
                        busy_q       <= 1'b1;
                        state_q      <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (!i_stall) begin
                        mem_addr_q <= word_idx_q;
                        issue_q    <= 1'b1;
                        if (word_idx_q == LAST_WORD) begin
                            state_q <= S_DRAIN;
                        end else begin
                            word_idx_q <= word_idx_q + ADDR_WIDTH'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (frame_cnt_q == FRAME_BEATS) begin
                        if (frame_idx_q != num_frames_q - 8'd1) begin
                            frame_idx_q <= frame_idx_q + 8'd1;
                            word_idx_q  <= '0;
                            frame_cnt_q <= '0;
                            state_q     <= S_STREAM;
                        end else begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Write path: one cycle of ROM latency, then the output register.
    // Runs independently of the FSM so a stall never drops in-flight beats.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            fetch_q <= 1'b0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
        end else begin
            fetch_q <= issue_q;
            wen_q   <= fetch_q;
            if (fetch_q) begin
                wdata_q <= i_mem_rdata;
            end
        end
    end

`ifdef DCT_STREAM_CHECKSUM_EN
    logic [31:0] lane_val [LANES];
    logic [31:0] lane_sum;
    logic [31:0] checksum_q;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign lane_val[gi] = 32'(i_rdata[gi*OUT_WIDTH +: OUT_WIDTH]);
    end

    // Sum of all lanes of the current returned beat, modulo 2^32.
    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_sum = lane_sum + lane_val[i];
        end
    end

    // Running checksum over counted beats, cleared when a run starts.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            checksum_q <= '0;
        end else if (start_accept) begin
            checksum_q <= '0;
        end else if (capture) begin
            checksum_q <= checksum_q + lane_sum;
        end
    end

    assign o_checksum = checksum_q;
`else
    logic unused_rdata;
    assign unused_rdata = ^i_rdata;
    assign o_checksum   = '0;
`endif

    assign o_mem_addr  = mem_addr_q;
    assign o_wdata     = wdata_q;
    assign o_wen       = wen_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_frame_idx = frame_idx_q;
    assign o_out_count = out_count_q;

endmodule

// File: tb/tb_dct_stream_driver.sv
// Scoreboard bench for dct_stream_driver: 16-pixel frames, 2 lanes, ROM word k
// holds pixels {2k+1, 2k}; DCT output is a 10-cycle loopback of the write beats.
module tb_dct_stream_driver;

    localparam int DW = 8;
    localparam int OW = 16;
    localparam int LN = 2;
    localparam int NP = 16;
    localparam int AW = 4;
`ifdef DCT_STREAM_CHECKSUM_EN
    localparam int CSUM_EN = 1;
`else
    localparam int CSUM_EN = 0;
`endif

    logic              clk;
    logic              resetn;
    logic              i_start;
    logic [7:0]        i_num_frames;
    logic              i_stall;
    logic [AW-1:0]     o_mem_addr;
    logic [LN*DW-1:0]  mem_rdata;
    logic [LN*DW-1:0]  o_wdata;
    logic              o_wen;
    logic [LN*OW-1:0]  i_rdata;
    logic              i_rsync;
    logic              o_busy;
    logic              o_done;
    logic [7:0]        o_frame_idx;
    logic [31:0]       o_out_count;
    logic [31:0]       o_checksum;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int done_cnt = 0;
    logic [15:0] exp_q [$];
    int          beat_cyc [$];
    logic [16:0] lb [10];

    // Hand-computed beat contents for one frame.
    logic [15:0] frame_words [8] = '{16'h0100, 16'h0302, 16'h0504, 16'h0706,
                                     16'h0908, 16'h0B0A, 16'h0D0C, 16'h0F0E};

    dct_stream_driver #(
        .DATA_WIDTH(DW), .OUT_WIDTH(OW), .LANES(LN), .NUM_PIXELS(NP), .ADDR_WIDTH(AW)
    ) dut (
        .i_clk(clk), .i_resetn(resetn), .i_start(i_start), .i_num_frames(i_num_frames),
        .i_stall(i_stall), .o_mem_addr(o_mem_addr), .i_mem_rdata(mem_rdata),
        .o_wdata(o_wdata), .o_wen(o_wen), .i_rdata(i_rdata), .i_rsync(i_rsync),
        .o_busy(o_busy), .o_done(o_done), .o_frame_idx(o_frame_idx),
        .o_out_count(o_out_count), .o_checksum(o_checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous pixel ROM.
    always @(posedge clk) begin
        mem_rdata <= {8'(2 * int'(o_mem_addr) + 1), 8'(2 * int'(o_mem_addr))};
    end

    // 10-cycle loopback of write beats onto the DCT return path.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 10; i++) lb[i] <= '0;
        end else begin
            lb[0] <= {o_wen, o_wdata};
            for (int i = 1; i < 10; i++) lb[i] <= lb[i-1];
        end
    end
    assign i_rsync = lb[9][16];
    assign i_rdata = {8'h00, lb[9][15:8], 8'h00, lb[9][7:0]};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every write beat, counts done pulses.
    always @(negedge clk) begin
        if (o_wen) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got %h required no beat", o_wdata);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                chk("wdata", 32'(o_wdata), 32'(e));
                $display("beat cyc=%0d data=%h expected=%h", cyc, o_wdata, e);
            end
            beat_cyc.push_back(cyc);
        end
        if (o_done) begin
            done_cnt++;
            chk("busy_at_done", 32'(o_busy), 32'd0);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic run(input int frames_in, input int exp_frames, input bit do_stall,
                       input bit restart_mid);
        int issue0;
        bit seen;
        logic [7:0] last_fi;
        int fi_steps [$];
        for (int f = 0; f < exp_frames; f++)
            for (int w = 0; w < 8; w++) exp_q.push_back(frame_words[w]);
        beat_cyc.delete();
        done_cnt = 0;
        issue0 = 0;
        i_num_frames = 8'(frames_in);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        chk("busy_after_start", 32'(o_busy), 32'd1);
        chk("frame_idx_start", 32'(o_frame_idx), 32'd0);
        chk("out_count_cleared", o_out_count, 32'd0);
        chk("checksum_cleared", o_checksum, 32'd0);
        for (int k = 0; k < 8; k++) begin
            step();
            if (k == 0) issue0 = cyc;
            chk("addr_seq", 32'(o_mem_addr), 32'(k));
            if (restart_mid && k == 4) begin
                i_num_frames = 8'd5;
                i_start = 1'b1;
            end
            if (restart_mid && k == 5) i_start = 1'b0;
            if (do_stall && k == 3) begin
                i_stall = 1'b1;
                for (int s = 0; s < 3; s++) begin
                    step();
                    chk("addr_hold_stall", 32'(o_mem_addr), 32'd3);
                end
                i_stall = 1'b0;
            end
        end
        seen = 1'b0;
        last_fi = 8'd0;
        for (int t = 0; t < 400 && !seen; t++) begin
            step();
            if (o_frame_idx != last_fi) begin
                fi_steps.push_back(int'(o_frame_idx));
                last_fi = o_frame_idx;
            end
            if (o_done) seen = 1'b1;
        end
        if (!seen) begin
            errors++;
            checks++;
            $display("FAIL done_timeout: got no o_done required one pulse");
        end
        chk("frame_idx_steps", 32'(fi_steps.size()), 32'(exp_frames - 1));
        for (int i = 0; i < fi_steps.size(); i++)
            chk("frame_idx_value", 32'(fi_steps[i]), 32'(i + 1));
        chk("out_count", o_out_count, 32'(8 * exp_frames));
        chk("checksum", o_checksum, 32'(CSUM_EN * 120 * exp_frames));
        step();
        chk("done_one_cycle", 32'(o_done), 32'd0);
        chk("busy_after_done", 32'(o_busy), 32'd0);
        chk("done_count", 32'(done_cnt), 32'd1);
        chk("out_count_hold", o_out_count, 32'(8 * exp_frames));
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        chk("beat_total", 32'(beat_cyc.size()), 32'(8 * exp_frames));
        if (beat_cyc.size() >= 8) begin
            chk("first_beat_latency", 32'(beat_cyc[0] - issue0), 32'd2);
            for (int i = 1; i < 8; i++)
                chk("beat_spacing", 32'(beat_cyc[i] - beat_cyc[i-1]),
                    (do_stall && i == 4) ? 32'd4 : 32'd1);
        end
        $display("run frames_in=%0d stall=%0d restart=%0d count=%0d checksum=%0d",
                 frames_in, do_stall, restart_mid, o_out_count, o_checksum);
    endtask

    initial begin
        resetn = 1'b0;
        i_start = 1'b0;
        i_num_frames = 8'd0;
        i_stall = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_wen", 32'(o_wen), 32'd0);
        chk("rst_wdata", 32'(o_wdata), 32'd0);
        chk("rst_addr", 32'(o_mem_addr), 32'd0);
        chk("rst_count", o_out_count, 32'd0);
        chk("rst_frame_idx", 32'(o_frame_idx), 32'd0);
        chk("rst_checksum", o_checksum, 32'd0);
        resetn = 1'b1;
        step();

        run(1, 1, 1'b0, 1'b0);   // single frame
        run(1, 1, 1'b1, 1'b0);   // stall after address 3
        run(3, 3, 1'b0, 1'b0);   // multi-frame
        run(0, 1, 1'b0, 1'b1);   // zero frames, start while busy

        // Reset mid-run at the fourth beat.
        for (int w = 0; w < 8; w++) exp_q.push_back(frame_words[w]);
        beat_cyc.delete();
        i_num_frames = 8'd1;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        for (int t = 0; t < 50 && beat_cyc.size() < 4; t++) step();
        chk("reset_reached_beat4", 32'(beat_cyc.size()), 32'd4);
        resetn = 1'b0;
        #1;
        chk("midrst_wen", 32'(o_wen), 32'd0);
        chk("midrst_busy", 32'(o_busy), 32'd0);
        chk("midrst_count", o_out_count, 32'd0);
        chk("midrst_frame_idx", 32'(o_frame_idx), 32'd0);
        chk("midrst_addr", 32'(o_mem_addr), 32'd0);
        exp_q.delete();
        step();
        resetn = 1'b1;
        step();
        run(1, 1, 1'b0, 1'b0);   // restart from address 0

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion required finish");
        $fatal(1, "watchdog");
    end

endmodule
